// File: rtl/acs_pm_k3.sv
// Add-compare-select and path-metric store for the K=3 (7,5) Viterbi decoder.
// Define PM_NORM_EN for subtractive metric normalization; otherwise metrics saturate.
module acs_pm_k3 #(
  parameter int PM_W    = 6,
  parameter int INIT_PM = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sync_clr,
  input  logic            in_valid,
  input  logic [7:0]      bm_in,
  output logic            out_valid,
  output logic [3:0]      decisions,
  output logic [1:0]      best_state,
  output logic [PM_W-1:0] best_pm
);

  logic [PM_W-1:0] pm_reg  [4];
  logic [PM_W-1:0] pm_next [4];
  logic [1:0]      bm      [4];
  logic [PM_W:0]   cand0   [4];
  logic [PM_W:0]   cand1   [4];
  logic [PM_W:0]   sel     [4];
  logic [3:0]      dec_next;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bm
      assign bm[gi] = bm_in[2*gi+1 -: 2];
    end

    // Next state ns={u,a} is reached from {a,0} and {a,1}.
    for (gi = 0; gi < 4; gi++) begin : g_acs
      localparam int A   = gi & 1;
      localparam int U   = (gi >> 1) & 1;
      localparam int PS0 = 2 * A;
      localparam int PS1 = 2 * A + 1;
      localparam int CW0 = (((U ^ A) & 1) << 1) | U;
      localparam int CW1 = (((U ^ A ^ 1) & 1) << 1) | (1 - U);

      assign cand0[gi]    = {1'b0, pm_reg[PS0]} + {{(PM_W-1){1'b0}}, bm[CW0]};
      assign cand1[gi]    = {1'b0, pm_reg[PS1]} + {{(PM_W-1){1'b0}}, bm[CW1]};
      assign dec_next[gi] = cand1[gi] < cand0[gi];
      assign sel[gi]      = dec_next[gi] ? cand1[gi] : cand0[gi];
    end

`ifdef PM_NORM_EN
    localparam logic [PM_W:0] HALF = (PM_W+1)'(1) << (PM_W-1);
    logic all_high;
    assign all_high = (sel[0] >= HALF) && (sel[1] >= HALF) &&
                      (sel[2] >= HALF) && (sel[3] >= HALF);
    for (gi = 0; gi < 4; gi++) begin : g_norm
      assign pm_next[gi] = all_high ? PM_W'(sel[gi] - HALF) : PM_W'(sel[gi]);
    end
`else
    for (gi = 0; gi < 4; gi++) begin : g_sat
      assign pm_next[gi] = sel[gi][PM_W] ? {PM_W{1'b1}} : sel[gi][PM_W-1:0];
    end
`endif
  endgenerate

  // Strict compares keep the lower index on equal metrics.
  logic [1:0]      best_state_next;
  logic [PM_W-1:0] best_pm_next;
  logic            b01, b23;
  logic [PM_W-1:0] m01, m23;

  always_comb begin
    b01 = 1'b0;
    m01 = pm_next[0];
    b23 = 1'b0;
    m23 = pm_next[2];
    if (pm_next[1] < pm_next[0]) begin
      b01 = 1'b1;
      m01 = pm_next[1];
    end
    if (pm_next[3] < pm_next[2]) begin
      b23 = 1'b1;
      m23 = pm_next[3];
    end
    best_state_next = {1'b0, b01};
    best_pm_next    = m01;
    if (m23 < m01) begin
      best_state_next = {1'b1, b23};
      best_pm_next    = m23;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++)
        pm_reg[i] <= (i == 0) ? '0 : PM_W'(INIT_PM);
      out_valid  <= 1'b0;
      decisions  <= '0;
      best_state <= '0;
      best_pm    <= '0;
    end else if (sync_clr) begin
      for (int i = 0; i < 4; i++)
        pm_reg[i] <= (i == 0) ? '0 : PM_W'(INIT_PM);
      out_valid <= 1'b0;
    end else if (in_valid) begin
      for (int i = 0; i < 4; i++)
        pm_reg[i] <= pm_next[i];
      out_valid  <= 1'b1;
      decisions  <= dec_next;
      best_state <= best_state_next;
      best_pm    <= best_pm_next;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acs_pm_k3.sv
// Directed bench for acs_pm_k3: hand-computed trellis steps, clears, saturation or
// normalization (follows PM_NORM_EN) and asynchronous reset mid-stream.
module tb_acs_pm_k3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sync_clr;
  logic       in_valid;
  logic [7:0] bm_in;
  logic       out_valid;
  logic [3:0] decisions;
  logic [1:0] best_state;
  logic [5:0] best_pm;

  always #5 clk = ~clk;

  acs_pm_k3 #(.PM_W(6), .INIT_PM(16)) dut (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid),
    .bm_in(bm_in), .out_valid(out_valid), .decisions(decisions),
    .best_state(best_state), .best_pm(best_pm)
  );

  typedef struct {
    logic       clr;
    logic       vld;
    logic [7:0] bm;
    logic       ev;
    logic [3:0] ed;
    logic [1:0] es;
    logic [5:0] ep;
  } vec_t;

  vec_t vecs[14];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic apply_row(input int i);
    @(negedge clk);
    sync_clr = vecs[i].clr;
    in_valid = vecs[i].vld;
    bm_in    = vecs[i].bm;
    @(posedge clk);
    #1;
    $display("row %0d clr=%0b vld=%0b bm=%h -> ov=%0b dec=%b bs=%0d bpm=%0d",
             i, vecs[i].clr, vecs[i].vld, vecs[i].bm, out_valid, decisions, best_state, best_pm);
    chk($sformatf("row%0d_out_valid", i), int'(out_valid), int'(vecs[i].ev));
    chk($sformatf("row%0d_decisions", i), int'(decisions), int'(vecs[i].ed));
    chk($sformatf("row%0d_best_state", i), int'(best_state), int'(vecs[i].es));
    chk($sformatf("row%0d_best_pm", i), int'(best_pm), int'(vecs[i].ep));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_decisions"}, int'(decisions), 0);
    chk({tag, "_best_state"}, int'(best_state), 0);
    chk({tag, "_best_pm"}, int'(best_pm), 0);
  endtask

  initial begin
    logic [3:0] hist [6];
    logic [1:0] st;
    logic [5:0] decoded;
    int         k;
    int         exp_pm;

    //          clr   vld   bm     ev    dec      bs    bpm
    vecs[0]  = '{1'b0, 1'b1, 8'h94, 1'b1, 4'b0000, 2'd0, 6'd0};
    vecs[1]  = '{1'b0, 1'b1, 8'hC3, 1'b1, 4'b0000, 2'd1, 6'd2};
    vecs[2]  = '{1'b0, 1'b1, 8'hE4, 1'b1, 4'b0110, 2'd2, 6'd2};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 1'b1, 4'b0000, 2'd1, 6'd2};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 2'd1, 6'd2};
    // Encoded 1,0,1,1,0,0 with an idle cycle after the third symbol
    vecs[5]  = '{1'b0, 1'b1, 8'h16, 1'b1, 4'b0000, 2'd2, 6'd0};
    vecs[6]  = '{1'b0, 1'b1, 8'h49, 1'b1, 4'b0000, 2'd1, 6'd0};
    vecs[7]  = '{1'b0, 1'b1, 8'h94, 1'b1, 4'b1111, 2'd2, 6'd0};
    vecs[8]  = '{1'b0, 1'b0, 8'h94, 1'b0, 4'b1111, 2'd2, 6'd0};
    vecs[9]  = '{1'b0, 1'b1, 8'h61, 1'b1, 4'b0000, 2'd3, 6'd0};
    vecs[10] = '{1'b0, 1'b1, 8'h61, 1'b1, 4'b1111, 2'd1, 6'd0};
    vecs[11] = '{1'b0, 1'b1, 8'h16, 1'b1, 4'b1111, 2'd0, 6'd0};
    // Clear together with a symbol: symbol dropped, metrics back to init
    vecs[12] = '{1'b1, 1'b1, 8'h94, 1'b0, 4'b1111, 2'd0, 6'd0};
    vecs[13] = '{1'b0, 1'b1, 8'hC3, 1'b1, 4'b0000, 2'd0, 6'd3};

    rst_n    = 1'b0;
    sync_clr = 1'b0;
    in_valid = 1'b0;
    bm_in    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    k = 0;
    for (int i = 0; i < 14; i++) begin
      apply_row(i);
      if (i inside {5, 6, 7, 9, 10, 11}) begin
        hist[k] = decisions;
        k++;
      end
    end

    // Traceback from state 0 through the six recorded steps
    st = 2'd0;
    for (int s = 5; s >= 0; s--) begin
      decoded[s] = st[1];
      st = {st[0], hist[s][st]};
    end
    $display("traceback decoded=%b end_state=%0d", decoded, st);
    chk("traceback_bits", int'(decoded), int'(6'b001101));
    chk("traceback_start", int'(st), 0);

    // Long all-3 stream from a cleared state
    @(negedge clk);
    sync_clr = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    sync_clr = 1'b0;
    in_valid = 1'b1;
    bm_in    = 8'hFF;
    exp_pm   = 0;
    for (int s = 1; s <= 40; s++) begin
      @(posedge clk);
      #1;
      exp_pm += 3;
`ifdef PM_NORM_EN
      if (exp_pm >= 32) exp_pm -= 32;
`else
      if (exp_pm > 63) exp_pm = 63;
`endif
      $display("ff step %0d -> ov=%0b dec=%b bs=%0d bpm=%0d", s, out_valid, decisions, best_state, best_pm);
      chk($sformatf("ff%0d_best_pm", s), int'(best_pm), exp_pm);
      chk($sformatf("ff%0d_decisions", s), int'(decisions), 0);
      chk($sformatf("ff%0d_best_state", s), int'(best_state), 0);
      chk($sformatf("ff%0d_out_valid", s), int'(out_valid), 1);
    end

    // Asynchronous reset in the middle of a clock period while streaming
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset -> ov=%0b dec=%b bs=%0d bpm=%0d", out_valid, decisions, best_state, best_pm);
    chk_zero("async_rst");
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply_row(0);
    apply_row(1);

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_out_valid", int'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
